// File: rtl/octant_histogram.sv
// octant_histogram: per-frame label histogram behind the octant labeller.
// Ports: clk, rst_n (async, active-low); label/in_valid/done from the
//   labeller; cnt_label/cnt_value/cnt_valid/cnt_ready drain stream;
//   max_label, frame_done, bad_label, overrun status outputs.
module octant_histogram #(
    parameter int NUM_LABELS = 8,
    parameter int CW         = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    label,
    input  logic          in_valid,
    input  logic          done,
    output logic [3:0]    cnt_label,
    output logic [CW-1:0] cnt_value,
    output logic          cnt_valid,
    input  logic          cnt_ready,
    output logic [3:0]    max_label,
    output logic          frame_done,
    output logic          bad_label,
    output logic          overrun
);

    localparam int IW = (NUM_LABELS > 1) ? $clog2(NUM_LABELS) : 1;
    localparam logic [3:0] LAST_IDX = 4'(NUM_LABELS - 1);
    localparam logic [3:0] MAX_LBL = 4'(NUM_LABELS);
    localparam logic [CW-1:0] SAT = '1;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        FIN   = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic          done_d;
    logic          frame_edge;
    logic [CW-1:0] cnt [NUM_LABELS];
    logic [3:0]    idx;
    logic [CW-1:0] best_count;
    logic [3:0]    best_label;
    logic [3:0]    max_q;
    logic          bad_q;
    logic          ovr_q;

    logic          label_ok;
    logic [IW-1:0] lbl_sel;
    logic [IW-1:0] idx_sel;
    logic [CW-1:0] cur;
    logic          accum_inc;
    logic          beat_acc;
    logic          beat_win;
    logic          last_beat;

    assign frame_edge = done & ~done_d;
    assign label_ok   = (label != 4'd0) && (label <= MAX_LBL);
    assign lbl_sel    = IW'(label - 4'd1);
    assign idx_sel    = IW'(idx);
    assign cur        = cnt[idx_sel];

    assign accum_inc = (state == ACCUM) & in_valid & label_ok;
    assign beat_acc  = (state == DRAIN) & cnt_ready;
    // Strict compare: on ties the earlier (lower) label keeps the lead,
    // and a zero count can never displace the initial "no label" state.
    assign beat_win  = cur > best_count;
    assign last_beat = beat_acc & (idx == LAST_IDX);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and drain/status outputs, all decoded from registers
    always_comb begin
        state_nxt  = state;
        cnt_valid  = 1'b0;
        cnt_label  = 4'd0;
        cnt_value  = '0;
        frame_done = 1'b0;
        unique case (state)
            ACCUM: begin
                if (frame_edge) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                cnt_valid = 1'b1;
                cnt_label = idx + 4'd1;
                cnt_value = cur;
                if (last_beat) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                frame_done = 1'b1;
                state_nxt  = ACCUM;
            end
            default: begin
                state_nxt = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_d <= 1'b0;
        end else begin
            done_d <= done;
        end
    end

    // Saturating per-label counters; the last point of a frame arrives
    // together with the done edge and is counted in that same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LABELS; i++) begin
                cnt[i] <= '0;
            end
        end else if (state == FIN) begin
            for (int i = 0; i < NUM_LABELS; i++) begin
                cnt[i] <= '0;
            end
        end else if (accum_inc) begin
            if (cnt[lbl_sel] != SAT) begin
                cnt[lbl_sel] <= cnt[lbl_sel] + 1'b1;
            end
        end
    end

    // Drain index and running maximum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= 4'd0;
            best_count <= '0;
            best_label <= 4'd0;
        end else if (state == FIN) begin
            idx        <= 4'd0;
            best_count <= '0;
            best_label <= 4'd0;
        end else if (state == ACCUM) begin
            idx <= 4'd0;
        end else if (beat_acc) begin
            idx <= idx + 4'd1;
            if (beat_win) begin
                best_count <= cur;
                best_label <= idx + 4'd1;
            end
        end
    end

    // The final beat may itself be the winner, so resolve it here so
    // that max_label is already valid during the frame_done cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q <= 4'd0;
        end else if (last_beat) begin
            max_q <= beat_win ? (idx + 4'd1) : best_label;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bad_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            if (in_valid && state == ACCUM && !label_ok) begin
                bad_q <= 1'b1;
            end
            if (in_valid && state != ACCUM) begin
                ovr_q <= 1'b1;
            end
        end
    end

    assign max_label = max_q;
    assign bad_label = bad_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_octant_histogram.sv
// tb_octant_histogram: scoreboard bench for octant_histogram.
// Drives a CW=16 and a CW=4 instance with identical stimulus.
module tb_octant_histogram;

    localparam int NL  = 8;
    localparam int SATV = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  label = 4'd0;
    logic        in_valid = 1'b0;
    logic        done = 1'b0;
    logic        cnt_ready = 1'b0;

    logic [3:0]  cnt_label;
    logic [15:0] cnt_value;
    logic        cnt_valid;
    logic [3:0]  max_label;
    logic        frame_done;
    logic        bad_label;
    logic        overrun;

    logic [3:0]  s_label;
    logic [3:0]  s_value;
    logic        s_valid;
    logic [3:0]  s_max;
    logic        s_fin;
    logic        s_bad;
    logic        s_ovr;

    octant_histogram #(.NUM_LABELS(NL), .CW(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .label(label), .in_valid(in_valid),
        .done(done), .cnt_label(cnt_label), .cnt_value(cnt_value),
        .cnt_valid(cnt_valid), .cnt_ready(cnt_ready),
        .max_label(max_label), .frame_done(frame_done),
        .bad_label(bad_label), .overrun(overrun)
    );

    octant_histogram #(.NUM_LABELS(NL), .CW(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .label(label), .in_valid(in_valid),
        .done(done), .cnt_label(s_label), .cnt_value(s_value),
        .cnt_valid(s_valid), .cnt_ready(cnt_ready),
        .max_label(s_max), .frame_done(s_fin),
        .bad_label(s_bad), .overrun(s_ovr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lbl;
        int val;
    } beat_t;

    beat_t bq[$];
    int    mq[$];
    int    mqs[$];
    int    mcnt[NL];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    beats = 0;
    int    fin_cnt = 0;
    bit    fin_seen = 1'b0;
    bit    exp_bad = 1'b0;
    bit    exp_ovr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int satv(input int v);
        return (v > SATV) ? SATV : v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame end: queue expected beats and winners, clear the model
    task automatic push_frame();
        int best;
        int bl;
        int bests;
        int bls;
        best = 0; bl = 0; bests = 0; bls = 0;
        for (int i = 0; i < NL; i++) begin
            bq.push_back('{lbl: i + 1, val: mcnt[i]});
            if (mcnt[i] > best) begin
                best = mcnt[i];
                bl = i + 1;
            end
            if (satv(mcnt[i]) > bests) begin
                bests = satv(mcnt[i]);
                bls = i + 1;
            end
            mcnt[i] = 0;
        end
        mq.push_back(bl);
        mqs.push_back(bls);
        beats = 0;
        fin_cnt = 0;
        fin_seen = 1'b0;
    endtask

    task automatic send(input int l, input bit last);
        in_valid = 1'b1;
        label = 4'(l);
        if (last) done = 1'b1;
        if (l >= 1 && l <= NL) mcnt[l-1]++;
        else exp_bad = 1'b1;
        if (last) push_frame();
        tick();
        in_valid = 1'b0;
    endtask

    task automatic edge_only();
        done = 1'b1;
        push_frame();
        tick();
    endtask

    task automatic drain(input int mode, input bit ovr, output int k);
        k = 0;
        chk("valid_latency", {31'd0, cnt_valid}, 1);
        while (!fin_seen && k < 100) begin
            cnt_ready = (mode == 0) ? 1'b1 : (k % 4 == 0 || k % 4 == 3);
            if (ovr && k == 2) begin
                in_valid = 1'b1;
                label = 4'd2;
                exp_ovr = 1'b1;
            end
            tick();
            in_valid = 1'b0;
            k++;
        end
        cnt_ready = 1'b0;
        chk("drain_done", {31'd0, fin_seen}, 1);
        chk("beats_accepted", beats, NL);
        chk("fin_pulses", fin_cnt, 1);
        chk("queue_empty", bq.size(), 0);
    endtask

    // Monitor: compare drain beats and frame results against the queues
    always @(negedge clk) begin
        if (rst_n) begin
            if (bq.size() == 0) begin
                chk("beat_unexpected", {31'd0, cnt_valid}, 0);
            end else if (cnt_valid || s_valid) begin
                chk("beat_label", cnt_label, bq[0].lbl);
                chk("beat_value", cnt_value, bq[0].val);
                chk("sat_label", s_label, bq[0].lbl);
                chk("sat_value", s_value, satv(bq[0].val));
                if (cnt_ready) begin
                    void'(bq.pop_front());
                    beats++;
                end
            end
            if (frame_done) begin
                fin_cnt++;
                fin_seen = 1'b1;
                if (mq.size() == 0) begin
                    chk("fin_unexpected", {31'd0, frame_done}, 0);
                end else begin
                    chk("max_label", max_label, mq.pop_front());
                    chk("sat_max_label", s_max, mqs.pop_front());
                    chk("sat_fin", {31'd0, s_fin}, 1);
                end
            end
        end
    end

    initial begin
        int k;
        for (int i = 0; i < NL; i++) mcnt[i] = 0;
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_cnt_valid", {31'd0, cnt_valid}, 0);
        chk("rst_cnt_label", cnt_label, 0);
        chk("rst_cnt_value", cnt_value, 0);
        chk("rst_max_label", max_label, 0);
        chk("rst_frame_done", {31'd0, frame_done}, 0);
        chk("rst_bad_label", {31'd0, bad_label}, 0);
        chk("rst_overrun", {31'd0, overrun}, 0);
        rst_n = 1'b1;
        tick();

        // Basic frame
        send(3, 0); send(3, 0); send(7, 0); send(1, 0); send(3, 1);
        drain(0, 0, k);
        chk("fin_latency", k, NL + 1);
        done = 1'b0;
        tick();

        // Backpressure
        send(3, 0); send(3, 0); send(7, 0); send(1, 0); send(3, 1);
        drain(1, 0, k);
        done = 1'b0;
        tick();

        // Tie
        send(2, 0); send(5, 0); send(5, 0); send(2, 1);
        drain(0, 0, k);
        done = 1'b0;
        tick();

        // Empty frame, then held done must not retrigger
        edge_only();
        drain(0, 0, k);
        send(5, 0);
        tick();
        tick();
        chk("no_retrigger", {31'd0, cnt_valid}, 0);
        done = 1'b0;
        tick();

        // Bad labels and overrun
        chk("bad_before", {31'd0, bad_label}, 0);
        send(0, 0);
        chk("bad_after_0", {31'd0, bad_label}, 1);
        send(9, 0);
        chk("sat_bad", {31'd0, s_bad}, {31'd0, exp_bad});
        send(6, 0); send(6, 1);
        drain(0, 1, k);
        chk("overrun", {31'd0, overrun}, {31'd0, exp_ovr});
        chk("sat_overrun", {31'd0, s_ovr}, 1);
        done = 1'b0;
        tick();

        // Saturation (CW=4 instance clamps at 15)
        for (int i = 0; i < 20; i++) send(4, 0);
        edge_only();
        drain(0, 0, k);
        done = 1'b0;
        tick();

        // Reset in the middle of a drain
        send(1, 0); send(2, 0); send(3, 0); send(8, 1);
        cnt_ready = 1'b1;
        tick(); tick(); tick();
        chk("mid_beats", beats, 3);
        rst_n = 1'b0;
        #1;
        bq.delete();
        mq.delete();
        mqs.delete();
        for (int i = 0; i < NL; i++) mcnt[i] = 0;
        exp_bad = 1'b0;
        exp_ovr = 1'b0;
        chk("mr_cnt_valid", {31'd0, cnt_valid}, 0);
        chk("mr_cnt_label", cnt_label, 0);
        chk("mr_cnt_value", cnt_value, 0);
        chk("mr_max_label", max_label, 0);
        chk("mr_frame_done", {31'd0, frame_done}, 0);
        chk("mr_bad_label", {31'd0, bad_label}, 0);
        chk("mr_overrun", {31'd0, overrun}, 0);
        cnt_ready = 1'b0;
        done = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_idle", {31'd0, cnt_valid}, 0);
        send(2, 0); send(2, 1);
        drain(0, 0, k);
        done = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
